// File: rtl/vga_timing_gen.sv
// Raster timing source: scan counters for color_mapper plus registered HS/VS/VDE/RGB for the encoder.
// Latency: DrawX/DrawY/FrameStart are combinational from the counters; sync/enable/colour are one pixel tick later.
// Backpressure: none; PixEn low freezes counters and every registered output.
// Optional build macro VGA_TEST_PATTERN_EN adds TestMode, which swaps input colour for 8 vertical bars of 80 px.
module vga_timing_gen #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       PixEn,
  input  logic [3:0] Red,
  input  logic [3:0] Green,
  input  logic [3:0] Blue,
`ifdef VGA_TEST_PATTERN_EN
  input  logic       TestMode,
`endif
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       FrameStart,
  output logic       HS,
  output logic       VS,
  output logic       VDE,
  output logic [3:0] RedOut,
  output logic [3:0] GreenOut,
  output logic [3:0] BlueOut
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // All boundaries pre-cast to the 10-bit counter width so every compare is unsigned 10-bit.
  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START   = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] HS_END     = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_START   = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] VS_END     = 10'(V_VISIBLE + V_FP + V_SYNC - 1);

  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hs_n_d;
  logic       vs_n_d;
  logic       vde_d;
  logic [3:0] red_src;
  logic [3:0] green_src;
  logic [3:0] blue_src;

`ifdef VGA_TEST_PATTERN_EN
  // Bar number of the current pixel; only 0..7 matter because wider counts fall in blanking.
  logic [2:0] bar_idx;
  assign bar_idx = 3'(hcount / 10'd80);
`endif

  // Scan position: horizontal counter wraps each line and carries into the line counter.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hcount <= '0;
      vcount <= '0;
    end else if (PixEn) begin
      if (hcount == H_LAST) begin
        hcount <= '0;
        vcount <= (vcount == V_LAST) ? 10'd0 : vcount + 10'd1;
      end else begin
        hcount <= hcount + 10'd1;
      end
    end
  end

  assign DrawX      = hcount;
  assign DrawY      = vcount;
  assign FrameStart = (hcount == 10'd0) && (vcount == 10'd0);

  // Sync windows and visible-area flag for the pixel currently addressed.
  always_comb begin
    hs_n_d = 1'b1;
    vs_n_d = 1'b1;
    if ((hcount >= HS_START) && (hcount <= HS_END)) hs_n_d = 1'b0;
    if ((vcount >= VS_START) && (vcount <= VS_END)) vs_n_d = 1'b0;
    vde_d = (hcount < H_VIS) && (vcount < V_VIS);
  end

  // Colour source: color_mapper by default, optionally the built-in bar pattern.
  always_comb begin
    red_src   = Red;
    green_src = Green;
    blue_src  = Blue;
`ifdef VGA_TEST_PATTERN_EN
    if (TestMode) begin
      red_src   = {4{bar_idx[1]}};
      green_src = {4{bar_idx[2]}};
      blue_src  = {4{bar_idx[0]}};
    end
`endif
  end

  // Output stage: one pixel behind the counters so colour from color_mapper lines up with its syncs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      HS       <= 1'b1;
      VS       <= 1'b1;
      VDE      <= 1'b0;
      RedOut   <= 4'h0;
      GreenOut <= 4'h0;
      BlueOut  <= 4'h0;
    end else if (PixEn) begin
      HS       <= hs_n_d;
      VS       <= vs_n_d;
      VDE      <= vde_d;
      RedOut   <= vde_d ? red_src   : 4'h0;
      GreenOut <= vde_d ? green_src : 4'h0;
      BlueOut  <= vde_d ? blue_src  : 4'h0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance plus a shrunken-geometry instance so whole frames fit in a short run.
// Expected outputs come from the pixel-tick count since reset (position = tick mod line/frame length).
// Both instances share clock, reset, enable and colour inputs.
module tb_vga_timing_gen;

  logic       Clk = 1'b0;
  logic       Reset_n;
  logic       PixEn;
  logic [3:0] Red, Green, Blue;
  logic       test_mode;

  logic [9:0] m_x, m_y, s_x, s_y;
  logic       m_fs, m_hs, m_vs, m_vde, s_fs, s_hs, s_vs, s_vde;
  logic [3:0] m_r, m_g, m_b, s_r, s_g, s_b;

  int   n_ticks = 0;
  logic [3:0] lr = 4'h0, lg = 4'h0, lb = 4'h0;
  logic ltm = 1'b0;
  int   checks = 0;
  int   fails  = 0;
  bit   chk_on = 1'b0;

  vga_timing_gen dut_main (
    .Clk(Clk), .Reset_n(Reset_n), .PixEn(PixEn),
    .Red(Red), .Green(Green), .Blue(Blue),
`ifdef VGA_TEST_PATTERN_EN
    .TestMode(test_mode),
`endif
    .DrawX(m_x), .DrawY(m_y), .FrameStart(m_fs),
    .HS(m_hs), .VS(m_vs), .VDE(m_vde),
    .RedOut(m_r), .GreenOut(m_g), .BlueOut(m_b)
  );

  vga_timing_gen #(
    .H_VISIBLE(16), .H_FP(2), .H_SYNC(3), .H_BP(4),
    .V_VISIBLE(12), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) dut_small (
    .Clk(Clk), .Reset_n(Reset_n), .PixEn(PixEn),
    .Red(Red), .Green(Green), .Blue(Blue),
`ifdef VGA_TEST_PATTERN_EN
    .TestMode(test_mode),
`endif
    .DrawX(s_x), .DrawY(s_y), .FrameStart(s_fs),
    .HS(s_hs), .VS(s_vs), .VDE(s_vde),
    .RedOut(s_r), .GreenOut(s_g), .BlueOut(s_b)
  );

  always #5 Clk = ~Clk;

  // Expected {x,y,fs,hs,vs,vde,r,g,b} after n pixel ticks; the registered half describes pixel n-1.
  function automatic logic [35:0] model(input int n, hv, hf, hsw, hb, vv, vf, vsw, vb,
                                        input logic [3:0] r, g, b, input logic tm);
    int ht, vt, x, y, px, py, bar;
    logic hs_e, vs_e, de;
    logic [3:0] ro, go, bo;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    x = n % ht;
    y = (n / ht) % vt;
    hs_e = 1'b1; vs_e = 1'b1; de = 1'b0;
    ro = 4'h0; go = 4'h0; bo = 4'h0;
    if (n > 0) begin
      px = (n - 1) % ht;
      py = ((n - 1) / ht) % vt;
      hs_e = !((px >= hv + hf) && (px < hv + hf + hsw));
      vs_e = !((py >= vv + vf) && (py < vv + vf + vsw));
      de = (px < hv) && (py < vv);
      if (tm) begin
        bar = px / 80;
        ro = ((bar & 2) != 0) ? 4'hF : 4'h0;
        go = ((bar & 4) != 0) ? 4'hF : 4'h0;
        bo = ((bar & 1) != 0) ? 4'hF : 4'h0;
      end else begin
        ro = r; go = g; bo = b;
      end
      if (!de) begin
        ro = 4'h0; go = 4'h0; bo = 4'h0;
      end
    end
    return {10'(x), 10'(y), (x == 0) && (y == 0), hs_e, vs_e, de, ro, go, bo};
  endfunction

  // Tick counter and the colour presented on the most recent tick.
  initial forever begin
    @(posedge Clk or negedge Reset_n);
    if (!Reset_n) begin
      n_ticks = 0;
    end else if (PixEn) begin
      lr = Red; lg = Green; lb = Blue; ltm = test_mode;
      n_ticks = n_ticks + 1;
    end
  end

  // Every-cycle comparison of both instances against the model.
  initial forever begin
    logic [35:0] exp_v, act_v;
    @(negedge Clk);
    if (chk_on) begin
      exp_v = model(n_ticks, 640, 16, 96, 48, 480, 10, 2, 33, lr, lg, lb, ltm);
      act_v = {m_x, m_y, m_fs, m_hs, m_vs, m_vde, m_r, m_g, m_b};
      checks++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL cycle_main tick=%0d actual=%h required=%h (x,y,fs,hs,vs,vde,rgb)", n_ticks, act_v, exp_v);
      end
      exp_v = model(n_ticks, 16, 2, 3, 4, 12, 2, 2, 3, lr, lg, lb, ltm);
      act_v = {s_x, s_y, s_fs, s_hs, s_vs, s_vde, s_r, s_g, s_b};
      checks++;
      if (act_v !== exp_v) begin
        fails++;
        $display("FAIL cycle_small tick=%0d actual=%h required=%h (x,y,fs,hs,vs,vde,rgb)", n_ticks, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  task automatic step();
    @(posedge Clk);
    #2;
  endtask

  initial begin
    int hs_fall1, hs_fall2, hs_low, vde_hi;
    int vs_low_s, vs_fall_s1, vs_fall_s2, fs_cnt_s, vde_hi_s;
    logic hs_prev, vs_prev_s;
    hs_fall1 = -1; hs_fall2 = -1; hs_low = 0; vde_hi = 0;
    vs_low_s = 0; vs_fall_s1 = -1; vs_fall_s2 = -1; fs_cnt_s = 0; vde_hi_s = 0;
    hs_prev = 1'b1; vs_prev_s = 1'b1;

    Reset_n = 1'b0; PixEn = 1'b0;
    Red = 4'hF; Green = 4'h7; Blue = 4'h0; test_mode = 1'b0;
    repeat (2) step();
    chk_on = 1'b1;
    step();
    chk("rst_hs", int'(m_hs), 1);
    chk("rst_vs", int'(m_vs), 1);
    chk("rst_vde", int'(m_vde), 0);
    chk("rst_rgb", int'({m_r, m_g, m_b}), 0);
    chk("rst_x", int'(m_x), 0);
    chk("rst_fs", int'(m_fs), 1);
    Reset_n = 1'b1;
    PixEn = 1'b1;

    // Continuous ticks: two-plus lines on the main instance, several frames on the small one.
    for (int k = 1; k <= 1700; k++) begin
      if (k > 800) begin
        Red = 4'(k); Green = 4'(k >> 4); Blue = 4'(k * 3);
      end
      step();
      if (!m_hs && hs_prev) begin
        if (hs_fall1 < 0) hs_fall1 = k;
        else if (hs_fall2 < 0) hs_fall2 = k;
      end
      hs_prev = m_hs;
      if (k <= 800 && !m_hs) hs_low++;
      if (k <= 800 && m_vde) vde_hi++;
      if (!s_vs && vs_prev_s) begin
        if (vs_fall_s1 < 0) vs_fall_s1 = k;
        else if (vs_fall_s2 < 0) vs_fall_s2 = k;
      end
      vs_prev_s = s_vs;
      if (k <= 475 && !s_vs) vs_low_s++;
      if (k <= 475 && s_vde) vde_hi_s++;
      if (s_fs) fs_cnt_s++;
      if (k == 640) chk("rgb_last_visible", int'({m_r, m_g, m_b}), 'hF70);
      if (k == 641) chk("rgb_blank_640", int'({m_r, m_g, m_b}), 0);
      if (k == 800) begin
        chk("wrap_x", int'(m_x), 0);
        chk("wrap_y", int'(m_y), 1);
      end
    end
    chk("hs_first_fall", hs_fall1, 657);
    chk("hs_second_fall", hs_fall2, 1457);
    chk("hs_low_width", hs_low, 96);
    chk("vde_per_line", vde_hi, 640);
    chk("small_vs_low", vs_low_s, 50);
    chk("small_vs_fall1", vs_fall_s1, 351);
    chk("small_vs_fall2", vs_fall_s2, 826);
    chk("small_fs_count", fs_cnt_s, 3);
    chk("small_vde_frame", vde_hi_s, 192);

    // One enable every fourth clock, then a 10-clock freeze.
    for (int c = 0; c < 40; c++) begin
      PixEn = ((c % 4) == 3);
      step();
    end
    chk("stall_x", int'(m_x), 110);
    chk("stall_y", int'(m_y), 2);
    PixEn = 1'b0;
    repeat (10) step();
    chk("hold_x", int'(m_x), 110);
    chk("hold_vde", int'(m_vde), 1);
    chk("hold_hs", int'(m_hs), 1);

    // Mid-frame asynchronous reset between clock edges.
    PixEn = 1'b1;
    Red = 4'hF; Green = 4'h7; Blue = 4'h0;
    repeat (190) step();
    chk("pre_rst_x", int'(m_x), 300);
    chk("pre_rst_vde", int'(m_vde), 1);
    Reset_n = 1'b0;
    #1;
    chk("async_x", int'(m_x), 0);
    chk("async_y", int'(m_y), 0);
    chk("async_hs", int'(m_hs), 1);
    chk("async_vs", int'(m_vs), 1);
    chk("async_vde", int'(m_vde), 0);
    chk("async_rgb", int'({m_r, m_g, m_b}), 0);
    repeat (3) step();
    Reset_n = 1'b1;
    chk("rel_x", int'(m_x), 0);
    chk("rel_y", int'(m_y), 0);
    chk("rel_vde", int'(m_vde), 0);
    step();
    chk("first_px_x", int'(m_x), 1);
    chk("first_px_vde", int'(m_vde), 1);
    chk("first_px_rgb", int'({m_r, m_g, m_b}), 'hF70);

`ifdef VGA_TEST_PATTERN_EN
    Reset_n = 1'b0;
    step();
    test_mode = 1'b1;
    Reset_n = 1'b1;
    for (int k = 1; k <= 601; k++) begin
      step();
      if (k == 1)   chk("bar_x0", int'({m_r, m_g, m_b}), 'h000);
      if (k == 86)  chk("bar_x85", int'({m_r, m_g, m_b}), 'h00F);
      if (k == 251) chk("bar_x250", int'({m_r, m_g, m_b}), 'hF0F);
      if (k == 601) chk("bar_x600", int'({m_r, m_g, m_b}), 'hFFF);
    end
    test_mode = 1'b0;
`endif

    step();
    chk_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
